// File: rtl/aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// aes_round_ctrl
//
// Iterative AES-128 encryption sequencer. Holds the 128-bit cipher state,
// the current round key and the round constant, and steps one round per
// clock through an external combinational round datapath and key-expansion
// step.
//
// Parameters
//   NR          number of rounds performed (1..10); the last one skips
//               mix-columns (signalled on rnd_last)
//
// Optional build macro
//   AES_ROUND_CTRL_B2B_EN  when defined, a new block can be accepted on the
//                          same edge that the finished ciphertext is taken,
//                          removing the idle cycle between blocks
//
// Ports
//   clk, rst                clock (rising edge) / synchronous active-high reset
//   in_valid/in_ready       plaintext + key handshake (in_data, in_key)
//   out_valid/out_ready     ciphertext handshake (out_data)
//   rnd_data/rnd_key/rnd_last -> round datapath, rnd_result <- datapath
//   kx_key/kx_rcon          -> key-expansion step, kx_next <- key expansion
//   busy                    high while rounds are being computed
//   round_idx               current round number, 0 when not running
// ---------------------------------------------------------------------------
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [127:0] in_key,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [127:0] rnd_data,
    output logic [127:0] rnd_key,
    output logic         rnd_last,
    input  logic [127:0] rnd_result,
    output logic [127:0] kx_key,
    output logic [7:0]   kx_rcon,
    input  logic [127:0] kx_next,
    output logic         busy,
    output logic [3:0]   round_idx
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [3:0] LP_NR = 4'(NR);

    // GF(2^8) doubling used to advance the round constant.
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    state_t         r_fsm;
    logic [127:0]   r_state;
    logic [127:0]   r_key;
    logic [7:0]     r_rcon;
    logic [3:0]     r_round;
    logic           r_out_valid;
    logic           r_busy;

    logic           w_in_ready;
    logic           w_accept;
    logic           w_in_run;
    logic           w_last;

    assign w_in_run = (r_fsm == S_RUN);
    assign w_last   = w_in_run && (r_round == LP_NR);

`ifdef AES_ROUND_CTRL_B2B_EN
    // In DONE a new block may enter on the same edge the result is consumed.
    assign w_in_ready = (r_fsm == S_IDLE) || ((r_fsm == S_DONE) && out_ready);
`else
    assign w_in_ready = (r_fsm == S_IDLE);
`endif

    assign w_accept = in_valid && w_in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_fsm       <= S_IDLE;
            r_state     <= '0;
            r_key       <= '0;
            r_rcon      <= 8'h01;
            r_round     <= '0;
            r_out_valid <= 1'b0;
            r_busy      <= 1'b0;
        end else if (w_accept) begin
            // Initial AddRoundKey is folded into the load.
            r_state     <= in_data ^ in_key;
            r_key       <= in_key;
            r_rcon      <= 8'h01;
            r_round     <= 4'd1;
            r_fsm       <= S_RUN;
            r_busy      <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            case (r_fsm)
                S_RUN: begin
                    r_state <= rnd_result;
                    r_key   <= kx_next;
                    r_rcon  <= xtime(r_rcon);
                    if (r_round == LP_NR) begin
                        r_fsm       <= S_DONE;
                        r_round     <= '0;
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                    end else begin
                        r_round <= r_round + 4'd1;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_fsm       <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                default: begin
                    r_fsm <= S_IDLE;
                end
            endcase
        end
    end

    // Datapath drive. Outside RUN the key path shows the held key so the
    // external logic sees deterministic values.
    assign rnd_data  = r_state;
    assign rnd_key   = w_in_run ? kx_next : r_key;
    assign rnd_last  = w_last;
    assign kx_key    = r_key;
    assign kx_rcon   = r_rcon;

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign out_data  = r_out_valid ? r_state : '0;
    assign busy      = r_busy;
    assign round_idx = r_round;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// ---------------------------------------------------------------------------
// tb_aes_round_ctrl
//
// Bench for aes_round_ctrl. Provides a behavioural AES round datapath and
// key-expansion step, and a block-level AES-128 reference used for
// random plaintext/key pairs. Two instances: NR=10 and NR=1.
// ---------------------------------------------------------------------------
module tb_aes_round_ctrl;

    localparam int NR = 10;
`ifdef AES_ROUND_CTRL_B2B_EN
    localparam int SPACING = NR + 1;
`else
    localparam int SPACING = NR + 2;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [127:0] in_data = '0;
    logic [127:0] in_key = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [127:0] out_data;
    logic [127:0] rnd_data, rnd_key, rnd_result, kx_key, kx_next;
    logic         rnd_last;
    logic [7:0]   kx_rcon;
    logic         busy;
    logic [3:0]   round_idx;

    logic         d1_in_valid = 1'b0;
    logic         d1_in_ready;
    logic         d1_out_valid;
    logic [127:0] d1_out_data;
    logic [127:0] d1_rnd_data, d1_rnd_key, d1_rnd_result, d1_kx_key, d1_kx_next;
    logic         d1_rnd_last;
    logic [7:0]   d1_kx_rcon;
    logic         d1_busy;
    logic [3:0]   d1_round_idx;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    // ---------------- AES behavioural helpers ----------------
    function automatic logic [7:0] xt(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] aa = a;
        logic [7:0] bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            aa = xt(aa);
            bb = bb >> 1;
        end
        return p;
    endfunction

    // S-box from its definition: multiplicative inverse then affine map.
    function automatic logic [7:0] sbox(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        logic [7:0] base = x;
        logic [7:0] e = 8'd254;
        logic [7:0] b;
        for (int i = 0; i < 8; i++) begin
            if (e[i]) r = gmul(r, base);
            base = gmul(base, base);
        end
        b = (x == 8'h00) ? 8'h00 : r;
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]}
                 ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] aes_round(input logic [127:0] s,
                                               input logic [127:0] k,
                                               input logic last);
        logic [7:0] b [16];
        logic [7:0] t [16];
        logic [7:0] m [16];
        logic [127:0] o;
        for (int i = 0; i < 16; i++) b[i] = sbox(s[127-8*i -: 8]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                t[r+4*c] = b[r+4*((c+r)%4)];
        for (int c = 0; c < 4; c++) begin
            if (last) begin
                for (int r = 0; r < 4; r++) m[4*c+r] = t[4*c+r];
            end else begin
                m[4*c+0] = gmul(t[4*c],8'h02) ^ gmul(t[4*c+1],8'h03) ^ t[4*c+2] ^ t[4*c+3];
                m[4*c+1] = t[4*c] ^ gmul(t[4*c+1],8'h02) ^ gmul(t[4*c+2],8'h03) ^ t[4*c+3];
                m[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2],8'h02) ^ gmul(t[4*c+3],8'h03);
                m[4*c+3] = gmul(t[4*c],8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3],8'h02);
            end
        end
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = m[i];
        return o ^ k;
    endfunction

    function automatic logic [127:0] aes_kx(input logic [127:0] k, input logic [7:0] rc);
        logic [31:0] w3 = k[31:0];
        logic [31:0] tmp;
        logic [31:0] n0, n1, n2, n3;
        tmp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
              ^ {rc, 24'h0};
        n0 = k[127:96] ^ tmp;
        n1 = k[95:64] ^ n0;
        n2 = k[63:32] ^ n1;
        n3 = k[31:0] ^ n2;
        return {n0, n1, n2, n3};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt,
                                             input logic [127:0] key, input int nr);
        logic [127:0] s = pt ^ key;
        logic [127:0] k = key;
        logic [7:0] rc = 8'h01;
        for (int r = 1; r <= nr; r++) begin
            k = aes_kx(k, rc);
            s = aes_round(s, k, r == nr);
            rc = xt(rc);
        end
        return s;
    endfunction

    // External datapath attached to each instance.
    assign rnd_result    = aes_round(rnd_data, rnd_key, rnd_last);
    assign kx_next       = aes_kx(kx_key, kx_rcon);
    assign d1_rnd_result = aes_round(d1_rnd_data, d1_rnd_key, d1_rnd_last);
    assign d1_kx_next    = aes_kx(d1_kx_key, d1_kx_rcon);

    aes_round_ctrl #(.NR(NR)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_key(in_key),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .rnd_data(rnd_data), .rnd_key(rnd_key), .rnd_last(rnd_last),
        .rnd_result(rnd_result), .kx_key(kx_key), .kx_rcon(kx_rcon),
        .kx_next(kx_next), .busy(busy), .round_idx(round_idx)
    );

    aes_round_ctrl #(.NR(1)) dut1 (
        .clk(clk), .rst(rst),
        .in_valid(d1_in_valid), .in_ready(d1_in_ready), .in_data(128'h0), .in_key(128'h0),
        .out_valid(d1_out_valid), .out_ready(1'b1), .out_data(d1_out_data),
        .rnd_data(d1_rnd_data), .rnd_key(d1_rnd_key), .rnd_last(d1_rnd_last),
        .rnd_result(d1_rnd_result), .kx_key(d1_kx_key), .kx_rcon(d1_kx_rcon),
        .kx_next(d1_kx_next), .busy(d1_busy), .round_idx(d1_round_idx)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    logic [7:0] rcon_tab [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
                                  8'h20, 8'h40, 8'h80, 8'h1b, 8'h36};

    // Enter at a negedge with the DUT idle; leaves at a negedge with it idle.
    task automatic run_block(input string tag, input logic [127:0] pt,
                             input logic [127:0] key, input logic [127:0] exp,
                             input int hold);
        int lat = 0;
        logic [127:0] held;
        in_valid = 1'b1; in_data = pt; in_key = key;
        out_ready = (hold == 0);
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        while (!out_valid && lat < 40) begin
            check({tag, " round_idx"}, 128'(round_idx), 128'(lat + 1));
            check({tag, " kx_rcon"}, 128'(kx_rcon), 128'(rcon_tab[lat % 10]));
            check({tag, " rnd_last"}, 128'(rnd_last), 128'(lat + 1 == NR));
            check({tag, " in_ready_run"}, 128'(in_ready), 128'(0));
            @(posedge clk); @(negedge clk);
            lat++;
        end
        check({tag, " latency"}, 128'(lat), 128'(NR));
        check({tag, " out_data"}, out_data, exp);
        held = out_data;
        if (hold > 0) begin
            for (int i = 0; i < hold; i++) begin
                in_valid = 1'b1;
                in_data = {$urandom, $urandom, $urandom, $urandom};
                in_key = {$urandom, $urandom, $urandom, $urandom};
                @(posedge clk); @(negedge clk);
                check({tag, " bp_valid"}, 128'(out_valid), 128'(1));
                check({tag, " bp_data"}, out_data, held);
                check({tag, " bp_in_ready"}, 128'(in_ready), 128'(0));
            end
            in_valid = 1'b0;
            out_ready = 1'b1;
        end
        @(posedge clk); @(negedge clk);
        check({tag, " post_valid"}, 128'(out_valid), 128'(0));
        check({tag, " post_in_ready"}, 128'(in_ready), 128'(1));
        check({tag, " post_busy"}, 128'(busy), 128'(0));
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : main
        logic [127:0] pt, key;
        int cyc, nacc, nout, wait_cyc;
        int t_out [2];
        logic [127:0] d_out [2];
        logic acc;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst out_valid", 128'(out_valid), 128'(0));
        check("rst out_data", out_data, 128'h0);
        check("rst busy", 128'(busy), 128'(0));
        check("rst round_idx", 128'(round_idx), 128'(0));
        check("rst in_ready", 128'(in_ready), 128'(1));
        check("rst kx_rcon", 128'(kx_rcon), 128'h01);

        // NR=1 instance: result one edge after accept
        d1_in_valid = 1'b1;
        @(posedge clk); @(negedge clk);
        d1_in_valid = 1'b0;
        check("nr1 busy", 128'(d1_busy), 128'(1));
        check("nr1 rnd_last", 128'(d1_rnd_last), 128'(1));
        @(posedge clk); @(negedge clk);
        check("nr1 out_valid", 128'(d1_out_valid), 128'(1));
        check("nr1 out_data", d1_out_data, aes_round(128'h0, aes_kx(128'h0, 8'h01), 1'b1));
        @(posedge clk); @(negedge clk);
        check("nr1 idle", 128'(d1_in_ready), 128'(1));

        // FIPS-197 App. B
        run_block("fipsB", 128'h3243f6a8885a308d313198a2e0370734,
                  128'h2b7e151628aed2a6abf7158809cf4f3c,
                  128'h3925841d02dc09fbdc118597196a0b32, 0);
        // FIPS-197 C.1 with 7 cycles of backpressure
        run_block("fipsC1bp", 128'h00112233445566778899aabbccddeeff,
                  128'h000102030405060708090a0b0c0d0e0f,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 7);

        // Random blocks against the reference model
        for (int i = 0; i < 4; i++) begin
            pt = {$urandom, $urandom, $urandom, $urandom};
            key = {$urandom, $urandom, $urandom, $urandom};
            run_block($sformatf("rand%0d", i), pt, key, aes_ref(pt, key, NR),
                      int'($urandom_range(0, 3)));
        end

        // Reset in round 5
        in_valid = 1'b1;
        in_data = {$urandom, $urandom, $urandom, $urandom};
        in_key = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); @(negedge clk);
        in_valid = 1'b0;
        wait_cyc = 0;
        while (round_idx != 4'd5 && wait_cyc < 20) begin
            @(posedge clk); @(negedge clk);
            wait_cyc++;
        end
        check("midrst reached round5", 128'(round_idx), 128'(5));
        rst = 1'b1;
        @(posedge clk); @(negedge clk);
        rst = 1'b0;
        check("midrst busy", 128'(busy), 128'(0));
        check("midrst out_valid", 128'(out_valid), 128'(0));
        check("midrst round_idx", 128'(round_idx), 128'(0));
        check("midrst kx_rcon", 128'(kx_rcon), 128'h01);
        check("midrst in_ready", 128'(in_ready), 128'(1));
        run_block("fipsC1", 128'h00112233445566778899aabbccddeeff,
                  128'h000102030405060708090a0b0c0d0e0f,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, 0);

        // Continuous stream: B then C.1
        out_ready = 1'b1;
        in_valid = 1'b1;
        in_data = 128'h3243f6a8885a308d313198a2e0370734;
        in_key = 128'h2b7e151628aed2a6abf7158809cf4f3c;
        cyc = 0; nacc = 0; nout = 0;
        while (nout < 2 && cyc < 80) begin
            if (out_valid) begin
                t_out[nout] = cyc;
                d_out[nout] = out_data;
                nout++;
            end
            acc = in_valid && in_ready;
            @(posedge clk); @(negedge clk);
            cyc++;
            if (acc) begin
                nacc++;
                if (nacc == 1) begin
                    in_data = 128'h00112233445566778899aabbccddeeff;
                    in_key = 128'h000102030405060708090a0b0c0d0e0f;
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        check("stream outputs", 128'(nout), 128'(2));
        if (nout == 2) begin
            check("stream spacing", 128'(t_out[1] - t_out[0]), 128'(SPACING));
            check("stream outB", d_out[0], 128'h3925841d02dc09fbdc118597196a0b32);
            check("stream outC1", d_out[1], 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
